// File: rtl/uart_txfifo.sv
// uart_txfifo: byte FIFO feeding the UART transmitter (ports: clk, n_rst sync active-low, n_we/wdata push, n_full, data/n_cs head with n_rd falling-edge pop; TXFIFO_LEVEL_EN adds level)
module uart_txfifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                n_we,
  input  logic [7:0]          wdata,
  output logic                n_full,
  output logic [7:0]          data,
  output logic                n_cs,
  input  logic                n_rd
`ifdef TXFIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);
  localparam int N = 1 << DEPTH_LOG2;
  logic [7:0] mem [N];
  logic [DEPTH_LOG2:0] wptr, rptr, wnext, rnext;
  logic rd_q, push, pop;
  always_comb begin
    push = !n_we && n_full;
    pop = !n_rd && rd_q && !n_cs;
    wnext = wptr + (DEPTH_LOG2+1)'(push);
    rnext = rptr + (DEPTH_LOG2+1)'(pop);
    data = n_cs ? 8'h00 : mem[rptr[DEPTH_LOG2-1:0]];
  end
  always_ff @(posedge clk)
    if (n_rst && push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
  always_ff @(posedge clk)
    if (!n_rst) begin
      wptr <= '0;
      rptr <= '0;
      rd_q <= 1'b1;
      n_cs <= 1'b1;
      n_full <= 1'b1;
`ifdef TXFIFO_LEVEL_EN
      level <= '0;
`endif
    end else begin
      wptr <= wnext;
      rptr <= rnext;
      rd_q <= n_rd;
      n_cs <= wnext == rnext;
      n_full <= wnext != {~rnext[DEPTH_LOG2], rnext[DEPTH_LOG2-1:0]};
`ifdef TXFIFO_LEVEL_EN
      level <= wnext - rnext;
`endif
    end
endmodule
